// File: rtl/hp_au_issue_if.sv
// Command and result handshake bundle for the hp_au_issue stage.
// The master side issues commands and consumes results; the issue stage is the slave.
interface hp_au_issue_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [SEL_W-1:0] out_sel;

  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_sel
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_sel
  );
endinterface

// File: rtl/hp_au_issue.sv
// Issue/capture stage around the combinational hp_au_top arithmetic unit.
// Commands queue in a small circular FIFO whose head feeds the AU; the AU
// result is captured into a single output register with its own handshake.
//
// state    | meaning
// ST_EMPTY | output register holds nothing, out_valid = 0
// ST_FULL  | output register holds a result, out_valid = 1
module hp_au_issue #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  hp_au_issue_if.slave            bus,
  output logic [WIDTH-1:0]        au_a,
  output logic [WIDTH-1:0]        au_b,
  output logic [SEL_W-1:0]        au_sel,
  input  logic [WIDTH-1:0]        au_result,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [SEL_W-1:0] mem_sel [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             fifo_nonempty;
  logic             push, pop;
  logic [WIDTH-1:0] out_result_q;
  logic [SEL_W-1:0] out_sel_q;

  // in_ready deliberately ignores a same-cycle pop, so out_ready never reaches it
  assign fifo_nonempty = (count != '0);
  assign bus.in_ready  = (count != FULL_CNT) && !flush;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = fifo_nonempty && ((state == ST_EMPTY) || bus.out_ready) && !flush;

  assign au_a   = fifo_nonempty ? mem_a[rd_ptr]   : '0;
  assign au_b   = fifo_nonempty ? mem_b[rd_ptr]   : '0;
  assign au_sel = fifo_nonempty ? mem_sel[rd_ptr] : '0;

  assign bus.out_valid  = (state == ST_FULL);
  assign bus.out_result = out_result_q;
  assign bus.out_sel    = out_sel_q;

  // FIFO storage; contents are don't-care until written so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= bus.in_a;
      mem_b[wr_ptr]   <= bus.in_b;
      mem_sel[wr_ptr] <= bus.in_sel;
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Output stage next state: a pop always fills, a consume without pop empties
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (pop) state_next = ST_FULL;
        ST_FULL:  if (bus.out_ready && !pop) state_next = ST_EMPTY;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Result capture: sample the AU on the head entry before the head advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_q <= '0;
      out_sel_q    <= '0;
    end else if (flush) begin
      out_result_q <= '0;
      out_sel_q    <= '0;
    end else if (pop) begin
      out_result_q <= au_result;
      out_sel_q    <= au_sel;
    end
  end
endmodule
